// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/idle sequencing for the lab stopwatch.
// Turns two debounced button levels into count-enable ticks, a one-cycle
// clear pulse and a display-hold level for the BCD counter and display mux.
// TICK_DIV must be at least 2 and must fit in DIV_W bits.

module stopwatch_ctrl #(
  parameter int TICK_DIV = 100000,
  parameter int DIV_W    = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_sp,
  input  logic       btn_lr,
  output logic       count_en,
  output logic       clr,
  output logic       hold,
  output logic       running,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  state_t           state_q;
  state_t           state_d;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_d;
  logic             sp_d;
  logic             lr_d;
  logic             press_sp;
  logic             press_lr;
  logic             counting;
  logic             clr_d;

  // A start/pause press in the same cycle as a lap/reset press wins outright;
  // the lap/reset press is dropped rather than remembered.
  assign press_sp = btn_sp & ~sp_d;
  assign press_lr = btn_lr & ~lr_d & ~press_sp;
  assign counting = (state_q == RUN) || (state_q == LAP);
  assign state    = state_q;

  // Button history for rising-edge detection; resets high so a button held
  // through reset release must be released and pressed again to count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_d <= 1'b1;
      lr_d <= 1'b1;
    end else begin
      sp_d <= btn_sp;
      lr_d <= btn_lr;
    end
  end

  // Next-state decode and clear request from the detected presses.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press_sp)      state_d = RUN;
        else if (press_lr) clr_d   = 1'b1;
      end
      RUN: begin
        if (press_sp)      state_d = PAUSE;
        else if (press_lr) state_d = LAP;
      end
      PAUSE: begin
        if (press_sp) begin
          state_d = RUN;
        end else if (press_lr) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end
      end
      LAP: begin
        if (press_sp)      state_d = PAUSE;
        else if (press_lr) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Prescaler next value: counts while timing, freezes in pause so the
  // partial tick survives a resume, and is zeroed whenever the watch is idle.
  always_comb begin
    div_d = div_cnt;
    unique case (state_q)
      RUN, LAP: begin
        if (div_cnt == DIV_LAST) div_d = '0;
        else                     div_d = div_cnt + DIV_W'(1);
      end
      PAUSE: begin
        if (press_lr) div_d = '0;
      end
      IDLE:    div_d = '0;
      default: div_d = '0;
    endcase
  end

  // State, prescaler and all outputs update together on the same edge; the
  // tick decision uses the state in force before that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_cnt  <= '0;
      count_en <= 1'b0;
      clr      <= 1'b0;
      hold     <= 1'b0;
      running  <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_cnt  <= div_d;
      count_en <= counting && (div_cnt == DIV_LAST);
      clr      <= clr_d;
      hold     <= (state_d == LAP);
      running  <= (state_d == RUN) || (state_d == LAP);
    end
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequencing controller for the lab stopwatch datapath.
- Turns two debounced push-button levels (start/pause, lap/reset) into a 4-state run/pause/lap/idle FSM.
- Generates the count-enable tick for the time counter, a one-cycle clear pulse, and a display-hold strobe for lap freeze.
- Sits between the debouncers and the BCD time counter / 7-seg display mux.

Parameters:
- TICK_DIV, 100000: clk cycles per count tick; must be ≥ 2.
- DIV_W, 17: width of the prescaler counter; must satisfy 2^DIV_W ≥ TICK_DIV.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- btn_sp  input  1  start/pause button level, debounced, synchronous to clk, high = pressed
- btn_lr  input  1  lap/reset button level, debounced, synchronous to clk, high = pressed
- count_en  output  1  one-cycle pulse; time counter increments
- clr  output  1  one-cycle pulse; time counter clears to zero
- hold  output  1  level; display shows latched value instead of live count
- running  output  1  level; high in RUN or LAP
- state  output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 LAP

Behaviour:
- Reset (rst_n low, async): state=IDLE, div_cnt=0, count_en=0, clr=0, hold=0, running=0, sp_d=1, lr_d=1.
  - Edge registers reset to 1, so a button held through reset release gives no press until it is released and pressed again.
- Edge detect:
  - sp_d/lr_d register the button levels every cycle.
  - press_sp = btn_sp & ~sp_d; press_lr = btn_lr & ~lr_d (combinational, one cycle per rising edge).
- Simultaneous press_sp and press_lr in one cycle: press_sp wins; press_lr is discarded (not queued).
- Transitions take effect at the clk edge that ends the cycle in which the press is detected.
- IDLE:
  - press_sp → RUN.
  - press_lr → stay IDLE, clr pulses.
- RUN:
  - press_sp → PAUSE.
  - press_lr → LAP; hold=1.
- LAP (counting continues, display frozen):
  - press_lr → RUN; hold=0.
  - press_sp → PAUSE; hold=0.
- PAUSE:
  - press_sp → RUN.
  - press_lr → IDLE; clr pulses; div_cnt=0.
- Registered outputs: clr, hold, running and state all change at the same edge as the state register. clr is high for exactly one cycle.
- Prescaler (div_cnt):
  - In RUN or LAP: increments each cycle and wraps TICK_DIV-1 → 0.
  - In PAUSE: holds its value, so partial-tick time is preserved across pause/resume.
  - In IDLE: forced to 0.
- count_en:
  - Registered; high for the one cycle after an edge where the current state ∈ {RUN, LAP} and div_cnt == TICK_DIV-1.
  - Tick and state change at the same edge: the tick decision uses the pre-edge state. Example: RUN with div_cnt==TICK_DIV-1 and press_sp issues the tick, wraps div_cnt to 0, then enters PAUSE.
- A button held for many cycles is one press.
- Button activity with no listed transition is ignored.
- clr and count_en are never high in the same cycle; clr is only issued from IDLE or PAUSE.
- Reset asserted mid-operation (any state, any div_cnt) returns everything to reset values immediately, with no clr pulse.

Test Plan:
1. TICK_DIV=4; release reset, pulse btn_sp one cycle → state 01 next edge, running=1; count_en pulses every 4 cycles, first pulse 4 cycles after entering RUN.
2. Running with div_cnt=2, press btn_sp → PAUSE, no count_en for 20 cycles; press btn_sp → RUN; first count_en after exactly 2 cycles (prescaler preserved).
3. RUN, press btn_lr → state 11, hold=1, count_en keeps pulsing every 4 cycles; press btn_lr → state 01, hold=0.
4. PAUSE, press btn_lr → state 00, clr high exactly 1 cycle, div_cnt=0; in IDLE press btn_lr → clr pulses again, state stays 00.
5. IDLE, raise btn_sp and btn_lr in the same cycle → state 01, no clr; hold both high 10 cycles → no further transitions.
6. Hold btn_sp high through rst_n deassert → stays IDLE; drop rst_n in LAP mid-count → all outputs 0 and state 00 asynchronously.
